// File: rtl/gf2m_sched_pkg.sv
// Shared types and sizing helpers for the GF(2^m) multiplier scheduler.
package gf2m_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int sched_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf2m_mul_sched_if.sv
// Requester-side bundle: operand request channel and result response channel.
interface gf2m_mul_sched_if #(
  parameter int WIDTH = 79,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]       rsp_c;
  logic                   rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_err
  );
endinterface

// File: rtl/gf2m_rr_arb.sv
// Combinational round-robin arbiter: first request at or after ptr+1, wrapping.
module gf2m_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output and temporary gets a default first, so no path infers a latch.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(ptr) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (gnt == '0 && req[cand_idx]) begin
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/gf2m_mul_sched.sv
// Shares one digit-serial GF(2^m) multiplier among N_REQ requesters, one operation at a time.
module gf2m_mul_sched
  import gf2m_sched_pkg::*;
#(
  parameter int WIDTH   = 79,
  parameter int N_REQ   = 4,
  parameter int MAX_LAT = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  gf2m_mul_sched_if.slave  bus,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_op_a,
  output logic [WIDTH-1:0] mul_op_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_op_c
);

  localparam int IDX_W = sched_clog2(N_REQ);
  localparam int WD_W  = sched_clog2(MAX_LAT);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, gnt_idx_q, arb_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic [WD_W-1:0]  wd_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, res_q;
  logic             err_q;
  logic             accept, wd_hit, rsp_hs;

  gf2m_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign accept = (state_q == IDLE) && (bus.req_valid != '0);
  assign rsp_hs = (state_q == RESP) && bus.rsp_ready[gnt_idx_q];
  // WAIT is entered with the counter at 0, so hitting MAX_LAT-2 here lands RESP
  // exactly MAX_LAT cycles after the start pulse.
  assign wd_hit = (wd_q == WD_W'(MAX_LAT - 2));

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    mul_start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = arb_gnt;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        mul_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mul_done || wd_hit) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid[gnt_idx_q] = 1'b1;
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_c   = (state_q == RESP) ? res_q : '0;
  assign bus.rsp_err = (state_q == RESP) && err_q;
  assign mul_op_a    = op_a_q;
  assign mul_op_b    = op_b_q;

  // NOTE: operand/result registers are reset as well, since they feed outputs that must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(N_REQ - 1);
      gnt_idx_q <= '0;
      wd_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_a_q    <= bus.req_a[arb_idx*WIDTH +: WIDTH];
            op_b_q    <= bus.req_b[arb_idx*WIDTH +: WIDTH];
            gnt_idx_q <= arb_idx;
          end
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          wd_q <= wd_q + WD_W'(1);
          if (mul_done) begin
            res_q <= mul_op_c;
            err_q <= 1'b0;
          end else if (wd_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) ptr_q <= gnt_idx_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_mul_sched.sv
// Directed bench for gf2m_mul_sched with a behavioural 6-cycle GF(2^79) multiplier.
module tb_gf2m_mul_sched;

  localparam int W       = 79;
  localparam int N       = 4;
  localparam int MAX_LAT = 16;
  localparam int L       = 6;
  localparam int BOUND   = 40;
  localparam logic [W-1:0] POLY_LOW = 79'h201;  // x^79 = x^9 + 1

  logic         clk = 1'b0;
  logic         rst_b;
  logic         mul_start;
  logic [W-1:0] mul_op_a, mul_op_b, mul_op_c;
  logic         mul_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // multiplier-model bookkeeping
  bit           stub_hang = 1'b0;
  bit           stale_done = 1'b0;
  bit           m_busy;
  int           m_cnt;
  logic [W-1:0] m_a, m_b;
  int           starts = 0;
  int           start_while_busy = 0;
  int           op_unstable = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf2m_mul_sched_if #(.WIDTH(W), .N_REQ(N)) bus ();

  gf2m_mul_sched #(
    .WIDTH   (W),
    .N_REQ   (N),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .mul_start (mul_start),
    .mul_op_a  (mul_op_a),
    .mul_op_b  (mul_op_b),
    .mul_done  (mul_done),
    .mul_op_c  (mul_op_c)
  );

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r = '0;
    logic [W-1:0] t = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) r ^= t;
      t = t[W-1] ? ((t << 1) ^ POLY_LOW) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] xpow(input int n);
    logic [W-1:0] one = 1;
    return one << n;
  endfunction

  // Behavioural multiplier: done pulse L cycles after start, junk on the product bus otherwise.
  initial begin
    mul_done = 1'b0;
    mul_op_c = '1;
    m_busy   = 1'b0;
    m_cnt    = 0;
    m_a      = '0;
    m_b      = '0;
    forever begin
      @(negedge clk);
      mul_done = stale_done;
      mul_op_c = '1;
      if (!rst_b) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (mul_op_a !== m_a || mul_op_b !== m_b) op_unstable++;
        if (mul_start) start_while_busy++;
        m_cnt++;
        if (m_cnt == L) begin
          mul_done = 1'b1;
          mul_op_c = gf_mul(m_a, m_b);
          m_busy   = 1'b0;
        end
      end else if (mul_start) begin
        starts++;
        if (!stub_hang) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_a    = mul_op_a;
          m_b    = mul_op_b;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_b         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
  endtask

  // Caller raises req_valid at a negedge; this waits for the grant, the response,
  // optionally stalls it for `hold` cycles, then completes the handshake.
  task automatic serve(input string nm, input int id, input logic [W-1:0] exp_c,
                       input logic exp_err, input int exp_lat, input int hold,
                       input bit drop, output int t_acc);
    int           waited;
    int           s0;
    int           busy_rdy;
    logic [N-1:0] mask;
    mask = N'(1) << id;
    #1;
    waited = 0;
    while (bus.req_ready == '0 && waited < BOUND) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({nm, " grant"}, bus.req_ready, mask);
    t_acc    = cyc;
    s0       = starts;
    busy_rdy = 0;
    @(negedge clk);
    if (drop) bus.req_valid[id] = 1'b0;
    waited = 0;
    while (bus.rsp_valid == '0 && waited < BOUND) begin
      if (bus.req_ready != '0) busy_rdy++;
      @(negedge clk);
      waited++;
    end
    check({nm, " latency"}, cyc - t_acc, exp_lat);
    check({nm, " rsp_valid"}, bus.rsp_valid, mask);
    check({nm, " rsp_c"}, bus.rsp_c, exp_c);
    check({nm, " rsp_err"}, bus.rsp_err, exp_err);
    check({nm, " one start"}, starts - s0, 1);
    check({nm, " no grant while busy"}, busy_rdy, 0);
    if (hold > 0) begin
      bus.rsp_ready = ~mask;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({nm, " held"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_c, 32'(starts - s0)},
              {mask, exp_err, exp_c, 32'd1});
      end
    end
    bus.rsp_ready = mask;
    @(negedge clk);
    bus.rsp_ready = '0;
    check({nm, " released"}, bus.rsp_valid, '0);
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t_acc;
    int prev;
    int waited;
    int spurious;

    vecs[0] = '{id: 0, a: 79'h1,    b: 79'h20,   c: 79'h20};
    vecs[1] = '{id: 1, a: xpow(78), b: 79'h2,    c: 79'h201};
    vecs[2] = '{id: 2, a: 79'h3,    b: 79'h3,    c: 79'h5};
    vecs[3] = '{id: 3, a: xpow(40), b: xpow(40), c: 79'h402};
    vecs[4] = '{id: 1, a: 79'hF0,   b: 79'h0,    c: 79'h0};
    vecs[5] = '{id: 2, a: 79'h1234, b: 79'h1,    c: 79'h1234};

    rst_b         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // reset state
    @(negedge clk);
    check("reset handshake outs", {bus.req_ready, bus.rsp_valid, mul_start, bus.rsp_err}, '0);
    check("reset data outs", {bus.rsp_c, mul_op_a, mul_op_b}, '0);
    rst_b = 1'b1;
    @(negedge clk);

    // table-driven single requests
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_ops(vecs[i].id, vecs[i].a, vecs[i].b);
      bus.req_valid[vecs[i].id] = 1'b1;
      serve($sformatf("vec%0d", i), vecs[i].id, vecs[i].c, 1'b0, L + 2, 0, 1'b1, t_acc);
    end

    // simultaneous requests 0 and 2 after reset: 0 first, then 2
    do_reset();
    set_ops(0, 79'h1, 79'h100);
    set_ops(2, 79'h3, 79'h100);
    bus.req_valid = 4'b0101;
    serve("simul0", 0, 79'h100, 1'b0, L + 2, 0, 1'b1, t_acc);
    serve("simul2", 2, 79'h300, 1'b0, L + 2, 0, 1'b1, t_acc);

    // round-robin fairness with all requesters pending, back-to-back period L+3
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), 79'h100);
    bus.req_valid = '1;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      serve($sformatf("rr%0d", k), k % N, W'((k % N + 1) << 8), 1'b0, L + 2, 0, k >= 4, t_acc);
      if (k > 0) check($sformatf("rr%0d period", k), t_acc - prev, L + 3);
      prev = t_acc;
    end

    // response backpressure on requester 1 for 20 cycles
    @(negedge clk);
    set_ops(1, xpow(78), xpow(2));
    bus.req_valid[1] = 1'b1;
    serve("backpressure", 1, 79'h402, 1'b0, L + 2, 20, 1'b1, t_acc);

    // watchdog: multiplier never answers, then a normal op clears err
    stub_hang = 1'b1;
    @(negedge clk);
    set_ops(2, 79'h5, 79'h7);
    bus.req_valid[2] = 1'b1;
    serve("watchdog", 2, 79'h0, 1'b1, MAX_LAT + 1, 0, 1'b1, t_acc);
    stub_hang = 1'b0;
    @(negedge clk);
    bus.req_valid[2] = 1'b1;
    serve("after watchdog", 2, 79'h1B, 1'b0, L + 2, 0, 1'b1, t_acc);

    // reset pulse during WAIT followed by a stale done
    @(negedge clk);
    set_ops(3, xpow(5), xpow(5));
    bus.req_valid[3] = 1'b1;
    #1;
    waited = 0;
    while (bus.req_ready == '0 && waited < BOUND) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("midreset grant", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("midreset handshake outs", {bus.req_ready, bus.rsp_valid, mul_start, bus.rsp_err}, '0);
    check("midreset data outs", {bus.rsp_c, mul_op_a, mul_op_b}, '0);
    repeat (2) @(negedge clk);
    rst_b      = 1'b1;
    stale_done = 1'b1;
    @(negedge clk);
    stale_done = 1'b0;
    spurious   = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid != '0 || mul_start) spurious++;
    end
    check("midreset no response", spurious, 0);
    bus.req_valid[3] = 1'b1;
    serve("post reset", 3, 79'h400, 1'b0, L + 2, 0, 1'b1, t_acc);

    check("start while busy", start_while_busy, 0);
    check("operands stable", op_unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gf2m_mul_sched.md
# gf2m_mul_sched

Round-robin scheduler that shares one `gf2m_mul` digit-serial GF(2^m) multiplier among `N_REQ` requesters. Each requester posts an operand pair with a valid/ready handshake. The scheduler issues the operation to the multiplier, waits for its `done` pulse, and returns the product on a per-requester valid/ready response channel. It sits between the ROLLO polynomial-arithmetic engines and the single multiplier instance, and guarantees the multiplier never sees `start` while busy.

## Interface
Parameters:
- `WIDTH`, 79: field element width m; must match the attached multiplier.
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_LAT`, 16: watchdog limit, in cycles, from `mul_start` to `mul_done`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_b`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: requester i has an operand pair pending.
- `req_ready`  out  N_REQ: one-hot; the operand pair of requester i is accepted this cycle.
- `req_a`  in  N_REQ*WIDTH: operand a of requester i, in slice [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH: operand b of requester i, same slicing.
- `rsp_valid`  out  N_REQ: one-hot; a result is available for requester i.
- `rsp_ready`  in  N_REQ: requester i accepts the result.
- `rsp_c`  out  WIDTH: shared result bus; meaningful only while a `rsp_valid` bit is set.
- `rsp_err`  out  1: qualifies the current result; the watchdog expired, so `rsp_c` is invalid.
- `mul_start`  out  1: one-cycle start pulse to the multiplier.
- `mul_op_a`, `mul_op_b`  out  WIDTH: operands to the multiplier; held stable from `mul_start` until `mul_done`.
- `mul_done`  in  1: done pulse from the multiplier.
- `mul_op_c`  in  WIDTH: product from the multiplier; valid in the `mul_done` cycle.

## Operation
FSM states:
- **IDLE**
  - If `req_valid` is non-zero, the arbiter picks `g`: the first set bit searching upward from `ptr+1`, wrapping modulo N_REQ.
  - `req_ready[g]=1` combinationally in the same cycle.
  - Capture `req_a[g]` and `req_b[g]` into the operand registers, register `g`, and go to ISSUE.
  - If `req_valid` is zero, stay in IDLE.
- **ISSUE**
  - `mul_start=1` for exactly this cycle.
  - Clear the watchdog counter and go to WAIT.
- **WAIT**
  - The watchdog counter increments every cycle.
  - On `mul_done`, capture `mul_op_c` into the result register, clear `err`, and go to RESP.
  - If the counter reaches MAX_LAT-1 without `mul_done`, set `err`, zero the result, and go to RESP.
- **RESP**
  - `rsp_valid[g]=1`, `rsp_c`=result, `rsp_err`=err.
  - When `rsp_ready[g]` is sampled high, set `ptr <= g` and go to IDLE.
  - Otherwise hold all outputs.

Rules:
- Only one operation is in flight; no new grant is made until the response handshake completes.
- A `mul_done` pulse outside WAIT is ignored.
- `rsp_ready` bits other than `g`, and requests arriving while not in IDLE, are ignored; those requesters keep `req_valid` high.
- A requester may drop `req_valid` before it is granted; it is not granted once dropped.
- Arithmetic is entirely inside the multiplier; the scheduler only moves data.

## Timing
- Reset values: state=IDLE, `ptr`=N_REQ-1 (so requester 0 wins first), and all of `req_ready`, `rsp_valid`, `mul_start`, `rsp_err`, `rsp_c`, `mul_op_a`, `mul_op_b` are 0.
- Request acceptance is cycle T (IDLE); `mul_start` is at T+1.
- For WIDTH=79, d=16, `mul_done` arrives at T+1+L, where L=WIDTH/d+2=6. RESP is entered at T+2+L and `rsp_valid` is high from T+2+L.
- Minimum request-to-request period with `rsp_ready` tied high: L+3 cycles.
- Asserting `rst_b` low at any point, including mid-WAIT, returns the block to IDLE immediately and discards the operation.
  - The multiplier may still emit a stale `done`; it is ignored because the state is not WAIT.
  - The multiplier must be reset together with the scheduler.

## Structure
- Package `gf2m_sched_pkg`:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - `IDX_W = CLOG2(N_REQ)`;
  - watchdog counter width `CLOG2(MAX_LAT)`.
- Sub-module `gf2m_rr_arb`:
  - Purely combinational: inputs `req[N_REQ]` and `ptr`; outputs one-hot `gnt` and encoded index.
  - The top level owns the FSM, registers and watchdog.

## Test plan
- **Single request:** requester 0 sends a=1, b=0x20 (x^5) against a real `gf2m_mul` -> `rsp_valid`=0001 at T+8, `rsp_c`=0x20, `rsp_err`=0.
- **Simultaneous requests:** requesters 0 and 2 request in the same cycle after reset -> 0 is served first, then 2. Exactly one `mul_start` per operation, and none while in WAIT.
- **Round-robin fairness:** all 4 requesters hold `req_valid` high for 8 operations -> grant order 0,1,2,3,0,1,2,3.
- **Response backpressure:** `rsp_ready[1]` is held low for 20 cycles -> `rsp_valid`, `rsp_c` and `rsp_err` stay stable, and no new `mul_start` is issued. The response completes on the first cycle `rsp_ready[1]`=1.
- **Watchdog:** a multiplier stub that never asserts done -> RESP is entered MAX_LAT cycles after `mul_start`, with `rsp_err`=1 and `rsp_c`=0.
- **Reset mid-operation:** `rst_b` pulsed low during WAIT, followed by a stale `mul_done` -> all outputs go to 0 and the state is IDLE. No response is issued, and the next request is served normally.
